// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the unified instruction/data memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  // An access faults when it is not word aligned or its word offset from the
  // base lands past the end of the array; addresses below the base wrap to a
  // huge offset and therefore fault as well.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
    logic [31:0] offset;
    offset = addr - base;
    return (addr[WORD_SHIFT-1:0] != '0) || ((offset >> WORD_SHIFT) >= depth);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port word RAM with write enable and a registered read port.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Write the addressed word when enabled; the read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory target for the multicycle core: one request at a time, fixed wait
// latency, one-cycle ready pulse, and a fault flag for bad addresses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        mem_ready_q, mem_ready_d;
  logic        mem_err_q, mem_err_d;

  logic          accept;
  logic          fault;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  // The ready cycle still counts as busy, so a new request is taken only once
  // both the FSM is idle and the previous pulse has gone.
  assign busy   = (state_q != IDLE) || mem_ready_q;
  assign accept = mem_req && !busy;
  assign fault  = addr_fault(adr_q, BASE_ADDR, DEPTH_WORDS);

  // While idle the RAM looks up the incoming address so a one-cycle latency
  // still has data ready in RESP; afterwards it tracks the captured address.
  // The store is gated by reset so an abandoned request never commits.
  assign ram_addr = (state_q == IDLE) ? AW'((Adr - BASE_ADDR) >> WORD_SHIFT)
                                      : AW'((adr_q - BASE_ADDR) >> WORD_SHIFT);
  assign ram_we   = (state_q == RESP) && write_q && !fault && !reset;

  mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state logic: capture in IDLE, count down in WAIT, respond in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = MemWrite;
          adr_d   = Adr;
          wdata_d = WriteData;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        mem_ready_d = 1'b1;
        mem_err_d   = fault;
        if (fault) begin
          read_data_d = '0;
        end else if (!write_q) begin
          read_data_d = ram_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign ReadData  = read_data_q;
  assign mem_ready = mem_ready_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default parameters (LATENCY=2,
// DEPTH_WORDS=256, BASE_ADDR=0).
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        mem_ready;
  logic        mem_err;
  logic        busy;

  int total;
  int bad;

  mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .MemWrite  (MemWrite),
    .Adr       (Adr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .busy      (busy)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the directed sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we,
                               input logic [31:0] adr, input logic [31:0] wd);
    mem_req   = req;
    MemWrite  = we;
    Adr       = adr;
    WriteData = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (called #1 after an edge), wait for the ready pulse with
  // a bounded loop, then confirm busy drops one cycle after the pulse.
  task automatic runAccess(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic err, output int lat);
    applyStimulus(1'b1, we, adr, wd);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    lat = 0;
    while (!mem_ready && lat < 20) begin
      step();
      lat++;
    end
    rd  = ReadData;
    err = mem_err;
    checkOutput({tag, "_latency"}, 32'(lat), 32'd2);
    checkOutput({tag, "_busyInReady"}, {31'd0, busy}, 32'd1);
    step();
    checkOutput({tag, "_readyDrops"}, {31'd0, mem_ready}, 32'd0);
    checkOutput({tag, "_busyDrops"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          pulses;

    total = 0;
    bad   = 0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_ReadData", ReadData, 32'h0);
    checkOutput("rst_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("rst_err", {31'd0, mem_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] preload word 3 and read it back");
    runAccess("st3", 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, rd, err, lat);
    checkOutput("st3_err", {31'd0, err}, 32'd0);
    runAccess("ld3", 1'b0, 32'h0000_000C, 32'h0, rd, err, lat);
    checkOutput("ld3_data", rd, 32'hDEAD_BEEF);
    checkOutput("ld3_err", {31'd0, err}, 32'd0);

    $display("[TB] store word 4, check commit timing, read back");
    runAccess("st4a", 1'b1, 32'h0000_0010, 32'hAAAA_0004, rd, err, lat);
    checkOutput("st4a_holdRead", rd, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("st4b_wordInWait", dut.u_array.mem_q[4], 32'hAAAA_0004);
    step();
    checkOutput("st4b_wordInResp", dut.u_array.mem_q[4], 32'hAAAA_0004);
    checkOutput("st4b_noEarlyReady", {31'd0, mem_ready}, 32'd0);
    step();
    checkOutput("st4b_ready", {31'd0, mem_ready}, 32'd1);
    checkOutput("st4b_wordAfter", dut.u_array.mem_q[4], 32'h1234_5678);
    step();
    checkOutput("st4b_busyDrops", {31'd0, busy}, 32'd0);
    runAccess("ld4", 1'b0, 32'h0000_0010, 32'h0, rd, err, lat);
    checkOutput("ld4_data", rd, 32'h1234_5678);

    $display("[TB] misaligned store");
    runAccess("mis", 1'b1, 32'h0000_0011, 32'hFFFF_FFFF, rd, err, lat);
    checkOutput("mis_err", {31'd0, err}, 32'd1);
    checkOutput("mis_data", rd, 32'h0);
    runAccess("ld4b", 1'b0, 32'h0000_0010, 32'h0, rd, err, lat);
    checkOutput("ld4b_data", rd, 32'h1234_5678);
    checkOutput("ld4b_err", {31'd0, err}, 32'd0);

    $display("[TB] out-of-range loads");
    runAccess("oor", 1'b0, 32'h0000_0400, 32'h0, rd, err, lat);
    checkOutput("oor_err", {31'd0, err}, 32'd1);
    checkOutput("oor_data", rd, 32'h0);
    runAccess("ld3b", 1'b0, 32'h0000_000C, 32'h0, rd, err, lat);
    checkOutput("ld3b_data", rd, 32'hDEAD_BEEF);
    runAccess("oorTop", 1'b0, 32'hFFFF_FFFC, 32'h0, rd, err, lat);
    checkOutput("oorTop_err", {31'd0, err}, 32'd1);
    checkOutput("oorTop_data", rd, 32'h0);

    $display("[TB] request while busy, held until accepted");
    applyStimulus(1'b1, 1'b0, 32'h0000_000C, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    checkOutput("bz_busyWait", {31'd0, busy}, 32'd1);
    step();
    checkOutput("bz_noReadyResp", {31'd0, mem_ready}, 32'd0);
    step();
    checkOutput("bz_ready1", {31'd0, mem_ready}, 32'd1);
    checkOutput("bz_data1", ReadData, 32'hDEAD_BEEF);
    step();
    checkOutput("bz_readyGap", {31'd0, mem_ready}, 32'd0);
    checkOutput("bz_busyGap", {31'd0, busy}, 32'd0);
    checkOutput("bz_dataHold", ReadData, 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("bz_accept2", {31'd0, busy}, 32'd1);
    step();
    checkOutput("bz_noReady2Early", {31'd0, mem_ready}, 32'd0);
    step();
    checkOutput("bz_ready2", {31'd0, mem_ready}, 32'd1);
    checkOutput("bz_data2", ReadData, 32'h1234_5678);
    step();
    checkOutput("bz_busyEnd", {31'd0, busy}, 32'd0);

    $display("[TB] request during wait that is dropped is not queued");
    applyStimulus(1'b1, 1'b0, 32'h0000_000C, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_ready) pulses++;
    end
    checkOutput("drop_pulses", 32'(pulses), 32'd1);
    checkOutput("drop_data", ReadData, 32'hDEAD_BEEF);
    checkOutput("drop_idle", {31'd0, busy}, 32'd0);

    $display("[TB] reset during wait of a store");
    runAccess("st2", 1'b1, 32'h0000_0008, 32'h2222_2222, rd, err, lat);
    runAccess("ld4c", 1'b0, 32'h0000_0010, 32'h0, rd, err, lat);
    applyStimulus(1'b1, 1'b1, 32'h0000_0008, 32'hBAD0_BAD0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rw_ReadData", ReadData, 32'h0);
    checkOutput("rw_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("rw_err", {31'd0, mem_err}, 32'd0);
    checkOutput("rw_busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_ready) pulses++;
    end
    checkOutput("rw_pulses", 32'(pulses), 32'd0);
    checkOutput("rw_word2", dut.u_array.mem_q[2], 32'h2222_2222);

    $display("[TB] reset in the response cycle of a store");
    applyStimulus(1'b1, 1'b1, 32'h0000_0008, 32'hBAD0_BAD0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rr_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("rr_busy", {31'd0, busy}, 32'd0);
    step();
    checkOutput("rr_noLatePulse", {31'd0, mem_ready}, 32'd0);
    runAccess("ld2", 1'b0, 32'h0000_0008, 32'h0, rd, err, lat);
    checkOutput("ld2_data", rd, 32'h2222_2222);
    checkOutput("ld2_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
